// File: rtl/neuron_mac_seq.sv
// Sequential Q1.6 MAC neuron: streams n_in weight/activation pairs, adds bias, saturates to 8 bits.
// Optional ReLU on the saturated result when NEURON_SEQ_RELU_EN is defined.
module neuron_mac_seq #(
  parameter int N_IN  = 16,
  parameter int AW    = $clog2(N_IN),
  parameter int ACC_W = 10 + $clog2(N_IN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   n_in,
  input  logic [7:0]    b,
  output logic          busy,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    w_data,
  input  logic [7:0]    x_data,
  output logic [7:0]    out_data,
  output logic          out_sat,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, BIAS, OUT} state_t;

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] MIN_V = -ACC_W'(128);

  state_t                   state;
  logic [AW:0]              n_lat;
  logic [AW:0]              n_clamp;
  logic signed [7:0]        b_lat;
  logic signed [ACC_W-1:0]  acc;
  logic                     acc_en;
  logic signed [15:0]       prod;
  logic signed [7:0]        term;
  logic signed [ACC_W-1:0]  sum;
  logic [7:0]               res;
  logic                     res_sat;
  logic                     unused_bits;

  always_comb begin
    n_clamp = (n_in > (AW+1)'(N_IN)) ? (AW+1)'(N_IN) : n_in;
    prod    = $signed(w_data) * $signed(x_data);
    // Same truncation as the single-neuron datapath: bits 14:13 are dropped.
    term        = {prod[15], prod[12:6]};
    unused_bits = ^{prod[14:13], prod[5:0]};
    sum     = acc + {{(ACC_W-8){b_lat[7]}}, b_lat};
    res     = sum[7:0];
    res_sat = 1'b0;
    if (sum > MAX_V) begin
      res     = 8'h7F;
      res_sat = 1'b1;
    end else if (sum < MIN_V) begin
      res     = 8'h80;
      res_sat = 1'b1;
    end
`ifdef NEURON_SEQ_RELU_EN
    if (res[7]) res = '0;
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      acc       <= '0;
      acc_en    <= 1'b0;
      n_lat     <= '0;
      b_lat     <= '0;
    end else begin
      // Data returns one cycle after each strobe, so accumulation trails rd_en by one cycle.
      acc_en <= rd_en;
      if (acc_en) acc <= acc + {{(ACC_W-8){term[7]}}, term};
      case (state)
        IDLE: begin
          if (start) begin
            n_lat   <= n_clamp;
            b_lat   <= b;
            acc     <= '0;
            rd_addr <= '0;
            busy    <= 1'b1;
            if (n_clamp != '0) begin
              state <= READ;
              rd_en <= 1'b1;
            end else begin
              state <= BIAS;
            end
          end
        end
        READ: begin
          if ({1'b0, rd_addr} == n_lat - (AW+1)'(1)) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            rd_addr <= rd_addr + AW'(1);
          end
        end
        DRAIN: state <= BIAS;
        BIAS: begin
          out_data  <= res;
          out_sat   <= res_sat;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Self-checking bench for neuron_mac_seq: arithmetic reference model plus per-cycle compare.
module tb_neuron_mac_seq;
  localparam int N_IN = 16;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   n_in = '0;
  logic [7:0]    b = '0;
  logic          busy;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    w_data = '0;
  logic [7:0]    x_data = '0;
  logic [7:0]    out_data;
  logic          out_sat;
  logic          out_valid;
  logic          out_ready = 1'b1;

  neuron_mac_seq #(.N_IN(N_IN)) dut (
    .clk(clk), .rst(rst), .start(start), .n_in(n_in), .b(b),
    .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr),
    .w_data(w_data), .x_data(x_data),
    .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  logic [7:0] wmem [N_IN];
  logic [7:0] xmem [N_IN];

  always @(posedge clk) begin
    if (rd_en) begin
      w_data <= wmem[rd_addr];
      x_data <= xmem[rd_addr];
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: sum of truncated Q1.6 products plus bias, clamped to 8 bits.
  function automatic void model(input int n, input int bias, output int d, output int s);
    int sum, wi, xi, p, q;
    sum = bias;
    for (int i = 0; i < n; i++) begin
      wi = int'($signed(wmem[i]));
      xi = int'($signed(xmem[i]));
      p  = wi * xi;
      q  = (p >>> 6) & 127;
      sum += (p < 0) ? q - 128 : q;
    end
    s = 0;
    d = sum;
    if (sum > 127) begin d = 127; s = 1; end
    else if (sum < -128) begin d = -128; s = 1; end
`ifdef NEURON_SEQ_RELU_EN
    if (d < 0) d = 0;
`endif
    d = d & 255;
  endfunction

  int m_t0, m_n, m_lat, m_data, m_sat;
  int run_id = 0;
  int seen_id = 0;
  bit act = 1'b0;
  bit hs_pend = 1'b0;
  bit rst_q = 1'b1;
  int c;
  bit er, ev;

  always @(negedge clk) begin
    if (run_id != seen_id) begin
      seen_id = run_id;
      act     = 1'b1;
      hs_pend = 1'b0;
    end
    if (rst_q || hs_pend) begin
      act     = 1'b0;
      hs_pend = 1'b0;
    end
    if (!act) begin
      chk("idle_busy", int'(busy), 0);
      chk("idle_rd_en", int'(rd_en), 0);
      chk("idle_valid", int'(out_valid), 0);
    end else begin
      c  = cyc - m_t0;
      er = (c >= 1) && (c <= m_n);
      ev = (c >= m_lat);
      chk("busy", int'(busy), (c >= 1) ? 1 : 0);
      chk("rd_en", int'(rd_en), int'(er));
      if (er) chk("rd_addr", int'(rd_addr), c - 1);
      chk("out_valid", int'(out_valid), int'(ev));
      if (ev) begin
        chk("out_data", int'(out_data), m_data);
        chk("out_sat", int'(out_sat), m_sat);
        if (out_ready) hs_pend = 1'b1;
      end
    end
    rst_q = rst;
  end

  task automatic launch(input int nv, input int bv);
    int nn, bb;
    nn = nv;
    bb = bv;
    @(posedge clk); #1;
    n_in  = nn[AW:0];
    b     = bb[7:0];
    start = 1'b1;
    m_n   = (nv > N_IN) ? N_IN : nv;
    m_lat = (m_n == 0) ? 2 : m_n + 3;
    m_t0  = cyc;
    model(m_n, int'($signed(b)), m_data, m_sat);
    run_id++;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while (act && cnt < 100) begin
      @(posedge clk);
      cnt++;
    end
    if (act) chk("idle_timeout", 0, 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic run(input int nv, input int bv, input int lit_d, input int lit_s,
                     input int lit_lat, input bit stall);
    int cnt, vcyc;
    if (stall) out_ready = 1'b0;
    launch(nv, bv);
    if (stall) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    cnt  = 0;
    vcyc = -1;
    while (cnt < 200 && vcyc < 0) begin
      @(negedge clk);
      if (out_valid) vcyc = cyc;
      cnt++;
    end
    if (vcyc < 0) begin
      chk("valid_timeout", 0, 1);
    end else begin
      chk("latency", vcyc - m_t0, lit_lat);
      if (lit_d >= 0) begin
        chk("lit_data", int'(out_data), lit_d);
        chk("lit_sat", int'(out_sat), lit_s);
      end
    end
    if (stall) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_idle();
  endtask

  task automatic fill(input logic [7:0] wv, input logic [7:0] xv);
    for (int i = 0; i < N_IN; i++) begin
      wmem[i] = wv;
      xmem[i] = xv;
    end
  endtask

  initial begin
    fill(8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_busy", int'(busy), 0);

    fill(8'h40, 8'h20);
    run(1, 'h10, 'h30, 0, 4, 1'b0);

    fill(8'h40, 8'h40);
    run(2, 0, 'h7F, 1, 5, 1'b0);

    fill(8'hC0, 8'h40);
`ifdef NEURON_SEQ_RELU_EN
    run(2, 'hC0, 'h00, 1, 5, 1'b0);
    run(1, 0, 'h00, 0, 4, 1'b0);
    run(0, 'hFB, 'h00, 0, 2, 1'b0);
`else
    run(2, 'hC0, 'h80, 1, 5, 1'b0);
    run(1, 0, 'hC0, 0, 4, 1'b0);
    run(0, 'hFB, 'hFB, 0, 2, 1'b0);
`endif

    for (int i = 0; i < N_IN; i++) begin
      wmem[i] = 8'(i * 9 - 60);
      xmem[i] = 8'(100 - i * 13);
    end
    run(20, 'h05, -1, 0, 19, 1'b0);

    fill(8'h08, 8'h40);
    run(16, 'hF0, 'h70, 0, 19, 1'b1);

    // Abort a long run with reset in its fifth cycle.
    fill(8'h33, 8'h55);
    launch(16, 'h20);
    repeat (3) @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_rd_en", int'(rd_en), 0);
    chk("abort_valid", int'(out_valid), 0);
    repeat (2) @(posedge clk);

    fill(8'h7F, 8'h7F);
    run(1, 0, 'h7C, 0, 4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
